// File: rtl/fwd_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_if
// Brief    : Decode-side request and execute-select response bundle for
//            fwd_hazard_unit.
// Revision : 1.0
// ============================================================================
interface fwd_hazard_if #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
);
    logic              freeze;
    logic              flush;
    logic              id_valid;
    logic [REG_AW-1:0] id_src1;
    logic [REG_AW-1:0] id_src2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] id_dest;
    logic              id_wr;
    logic              id_load;
    logic [1:0]        alu_src1;
    logic [1:0]        alu_src2;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output freeze, flush, id_valid, id_src1, id_src2, id_use1, id_use2,
               id_dest, id_wr, id_load,
        input  alu_src1, alu_src2, stall, stall_count
    );

    modport slave (
        input  freeze, flush, id_valid, id_src1, id_src2, id_use1, id_use2,
               id_dest, id_wr, id_load,
        output alu_src1, alu_src2, stall, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : Operand-forwarding select generation and load-use stall control
//            for the 5-stage core, clocked alongside the ID/EX register.
// Revision : 1.0
// ============================================================================
module fwd_hazard_unit #(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fwd_hazard_if.slave   hz
);
    localparam logic [1:0]       C_SEL_RF  = 2'b00;
    localparam logic [1:0]       C_SEL_EX  = 2'b01;
    localparam logic [1:0]       C_SEL_MEM = 2'b10;
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    // Shadow entries mirror the instructions now in EX (e_*) and MEM (m_*)
    logic              e_valid_q, e_valid_d;
    logic [REG_AW-1:0] e_dest_q,  e_dest_d;
    logic              e_wr_q,    e_wr_d;
    logic              e_load_q,  e_load_d;
    logic              m_valid_q, m_valid_d;
    logic [REG_AW-1:0] m_dest_q,  m_dest_d;
    logic              m_wr_q,    m_wr_d;
    logic [1:0]        src1_q,    src1_d;
    logic [1:0]        src2_q,    src2_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    logic       w_e_hit1, w_e_hit2, w_m_hit1, w_m_hit2;
    logic [1:0] w_sel1, w_sel2;
    logic       w_hz, w_stall;

    always_comb begin
        w_e_hit1 = hz.id_use1 && e_valid_q && e_wr_q && (e_dest_q == hz.id_src1);
        w_e_hit2 = hz.id_use2 && e_valid_q && e_wr_q && (e_dest_q == hz.id_src2);
        w_m_hit1 = hz.id_use1 && m_valid_q && m_wr_q && (m_dest_q == hz.id_src1);
        w_m_hit2 = hz.id_use2 && m_valid_q && m_wr_q && (m_dest_q == hz.id_src2);

        // Youngest producer wins when both shadow entries match
        w_sel1 = w_e_hit1 ? C_SEL_EX : (w_m_hit1 ? C_SEL_MEM : C_SEL_RF);
        w_sel2 = w_e_hit2 ? C_SEL_EX : (w_m_hit2 ? C_SEL_MEM : C_SEL_RF);

        w_hz    = hz.id_valid && e_load_q && (w_e_hit1 || w_e_hit2);
        w_stall = w_hz && !hz.flush && !hz.freeze;
    end

    always_comb begin
        e_valid_d = e_valid_q;
        e_dest_d  = e_dest_q;
        e_wr_d    = e_wr_q;
        e_load_d  = e_load_q;
        m_valid_d = m_valid_q;
        m_dest_d  = m_dest_q;
        m_wr_d    = m_wr_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        cnt_d     = cnt_q;

        if (!hz.freeze) begin
            m_valid_d = e_valid_q;
            m_dest_d  = e_dest_q;
            m_wr_d    = e_wr_q;

            if (w_stall || hz.flush || !hz.id_valid) begin
                e_valid_d = 1'b0;
                e_dest_d  = '0;
                e_wr_d    = 1'b0;
                e_load_d  = 1'b0;
                src1_d    = C_SEL_RF;
                src2_d    = C_SEL_RF;
            end else begin
                e_valid_d = 1'b1;
                e_dest_d  = hz.id_dest;
                e_wr_d    = hz.id_wr;
                e_load_d  = hz.id_load;
                src1_d    = w_sel1;
                src2_d    = w_sel2;
            end

            if (w_stall && (cnt_q != C_CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid_q <= 1'b0;
            e_dest_q  <= '0;
            e_wr_q    <= 1'b0;
            e_load_q  <= 1'b0;
            m_valid_q <= 1'b0;
            m_dest_q  <= '0;
            m_wr_q    <= 1'b0;
            src1_q    <= C_SEL_RF;
            src2_q    <= C_SEL_RF;
            cnt_q     <= '0;
        end else begin
            e_valid_q <= e_valid_d;
            e_dest_q  <= e_dest_d;
            e_wr_q    <= e_wr_d;
            e_load_q  <= e_load_d;
            m_valid_q <= m_valid_d;
            m_dest_q  <= m_dest_d;
            m_wr_q    <= m_wr_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign hz.alu_src1    = src1_q;
    assign hz.alu_src2    = src2_q;
    assign hz.stall       = w_stall;
    assign hz.stall_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Brief    : Scenario bench for fwd_hazard_unit; a narrow-counter twin shares
//            the stimulus to reach counter saturation quickly.
// Revision : 1.0
// ============================================================================
module tb_fwd_hazard_unit;
    logic clk;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    typedef struct packed {
        logic [1:0] s1;
        logic [1:0] s2;
    } sel_t;
    sel_t sb[$];

    fwd_hazard_if #(.REG_AW(3), .CNT_W(16)) bus ();
    fwd_hazard_if #(.REG_AW(3), .CNT_W(2))  sat_bus ();

    fwd_hazard_unit #(.REG_AW(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    fwd_hazard_unit #(.REG_AW(3), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .hz  (sat_bus)
    );

    assign sat_bus.freeze   = bus.freeze;
    assign sat_bus.flush    = bus.flush;
    assign sat_bus.id_valid = bus.id_valid;
    assign sat_bus.id_src1  = bus.id_src1;
    assign sat_bus.id_src2  = bus.id_src2;
    assign sat_bus.id_use1  = bus.id_use1;
    assign sat_bus.id_use2  = bus.id_use2;
    assign sat_bus.id_dest  = bus.id_dest;
    assign sat_bus.id_wr    = bus.id_wr;
    assign sat_bus.id_load  = bus.id_load;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One decode cycle: stall checked mid-cycle, selects checked after the edge
    task automatic issue(input logic v, input logic [2:0] s1, input logic u1,
                         input logic [2:0] s2, input logic u2, input logic [2:0] d,
                         input logic w, input logic ld, input logic fl, input logic fz,
                         input logic es, input logic [1:0] e1, input logic [1:0] e2,
                         input string nm);
        sel_t exp;
        bus.id_valid = v;  bus.id_src1 = s1; bus.id_use1 = u1;
        bus.id_src2  = s2; bus.id_use2 = u2; bus.id_dest = d;
        bus.id_wr    = w;  bus.id_load = ld; bus.flush   = fl; bus.freeze = fz;
        @(negedge clk);
        vectors++;
        if (bus.stall !== es) begin
            miscompares++;
            $display("FAIL %s stall: got %b expected %b", nm, bus.stall, es);
        end
        sb.push_back('{s1: e1, s2: e2});
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        vectors++;
        if ({bus.alu_src1, bus.alu_src2} !== {exp.s1, exp.s2}) begin
            miscompares++;
            $display("FAIL %s alu_src: got %b/%b expected %b/%b", nm,
                     bus.alu_src1, bus.alu_src2, exp.s1, exp.s2);
        end
    endtask

    task automatic check_count(input logic [15:0] exp, input logic [1:0] exp_sat,
                               input string nm);
        vectors++;
        if (bus.stall_count !== exp) begin
            miscompares++;
            $display("FAIL %s stall_count: got %0d expected %0d", nm, bus.stall_count, exp);
        end
        vectors++;
        if (sat_bus.stall_count !== exp_sat) begin
            miscompares++;
            $display("FAIL %s sat_count: got %0d expected %0d", nm, sat_bus.stall_count, exp_sat);
        end
    endtask

    task automatic drain(input string nm);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, nm);
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.freeze = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b1;
        bus.id_src1 = 3'($urandom); bus.id_src2 = 3'($urandom);
        bus.id_use1 = 1'b1; bus.id_use2 = 1'b1;
        bus.id_dest = 3'($urandom); bus.id_wr = 1'b1; bus.id_load = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.alu_src1, bus.alu_src2, bus.stall} !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset outputs: got %b/%b stall %b expected 00/00 stall 0",
                     bus.alu_src1, bus.alu_src2, bus.stall);
        end
        check_count(16'd0, 2'd0, "reset");
        rst = 1'b0;
        drain("reset_drain");
    endtask

    task automatic test_ex_forward();
        issue(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, "ex_prod");
        issue(1, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0, 2'b01, 2'b00, "ex_cons");
        drain("ex_drain");
    endtask

    task automatic test_mem_forward();
        issue(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, "mem_prod");
        issue(1, 6, 1, 7, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, "mem_indep");
        issue(1, 4, 1, 1, 1, 2, 1, 0, 0, 0, 0, 2'b00, 2'b10, "mem_cons");
        drain("mem_drain");
    endtask

    task automatic test_load_use();
        issue(1, 3, 1, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, "lu_load");
        issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, "lu_stall");
        issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0, 2'b10, 2'b10, "lu_retry");
        check_count(16'd1, 2'd1, "lu");
        drain("lu_drain");
    endtask

    task automatic test_priority_nowrite();
        issue(1, 1, 1, 2, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, "pri_add");
        issue(1, 4, 1, 5, 1, 3, 1, 0, 0, 0, 0, 2'b00, 2'b00, "pri_sub");
        issue(1, 3, 1, 6, 1, 7, 1, 0, 0, 0, 0, 2'b01, 2'b00, "pri_cons");
        drain("pri_drain");
        issue(1, 1, 1, 2, 1, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, "nw_store");
        issue(1, 3, 1, 3, 1, 5, 1, 0, 0, 0, 0, 2'b00, 2'b00, "nw_cons_e");
        issue(1, 3, 1, 3, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b00, "nw_cons_m");
        drain("nw_drain");
    endtask

    task automatic test_flush();
        issue(1, 3, 1, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, "fl_load");
        issue(1, 2, 1, 2, 1, 6, 1, 0, 1, 0, 0, 2'b00, 2'b00, "fl_flush");
        check_count(16'd1, 2'd1, "flush");
        drain("fl_drain");
    endtask

    task automatic test_freeze();
        issue(1, 6, 1, 7, 1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, "fz_add");
        issue(1, 1, 1, 0, 0, 2, 1, 1, 0, 0, 0, 2'b01, 2'b00, "fz_load");
        for (int i = 0; i < 3; i++) begin
            issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 1, 0, 2'b01, 2'b00, "fz_hold");
            check_count(16'd1, 2'd1, "fz_hold");
        end
        issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, "fz_stall");
        issue(1, 2, 1, 2, 1, 6, 1, 0, 0, 0, 0, 2'b10, 2'b10, "fz_retry");
        check_count(16'd2, 2'd2, "fz_after");
        drain("fz_drain");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 2; i++) begin
            issue(1, 3, 1, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, "sat_load");
            issue(1, 0, 0, 2, 1, 6, 1, 0, 0, 0, 1, 2'b00, 2'b00, "sat_stall");
            issue(1, 0, 0, 2, 1, 6, 1, 0, 0, 0, 0, 2'b00, 2'b10, "sat_retry");
            drain("sat_drain");
        end
        check_count(16'd4, 2'd3, "saturate");
    endtask

    task automatic test_reset_mid_stall();
        issue(1, 3, 1, 0, 0, 2, 1, 1, 0, 0, 0, 2'b00, 2'b00, "rms_load");
        bus.id_valid = 1'b1; bus.id_src1 = 3'd2; bus.id_use1 = 1'b1;
        bus.id_src2 = 3'd2; bus.id_use2 = 1'b1; bus.id_dest = 3'd6;
        bus.id_wr = 1'b1; bus.id_load = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.stall !== 1'b1) begin
            miscompares++;
            $display("FAIL rms pre-stall: got %b expected 1", bus.stall);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus.stall, bus.alu_src1, bus.alu_src2} !== 5'b00000) begin
            miscompares++;
            $display("FAIL rms outputs: got stall %b sel %b/%b expected 0 00/00",
                     bus.stall, bus.alu_src1, bus.alu_src2);
        end
        check_count(16'd0, 2'd0, "rms");
        @(posedge clk);
        #1;
        bus.id_valid = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ex_forward();
        test_mem_forward();
        test_load_use();
        test_priority_nowrite();
        test_flush();
        test_freeze();
        test_saturate();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
